effect_scheduler: RTL and testbench

//  Divides clk down to the audio sample rate. On each sample tick, sequences the shared effect datapath

---
 rtl/effect_scheduler.sv | 106 ++++++++++
 tb/tb_effect_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/effect_scheduler.sv
// Sample-rate divider and per-channel start/done sequencer for the shared effect datapath.
// Build option OVERRUN_CNT_EN adds an 8-bit saturating overrun event counter port.
module effect_scheduler #(
  parameter int CLK_DIV = 2268,
  parameter int DIV_W   = 12,
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            clr_i,
  input  logic            done_i,
  output logic            sample_tick_o,
  output logic            start_o,
  output logic [CH_W-1:0] ch_o,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            overrun_o,
  output logic            timeout_o
`ifdef OVERRUN_CNT_EN
  ,
  output logic [7:0]      overrun_cnt_o
`endif
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [CH_W-1:0]  ch;
  logic [WD_W-1:0]  wdog;
  logic             frame_done_q, overrun_q, timeout_q;
  logic             tick, wd_expired, ch_end, last_ch, abort, overrun_set;

  // Tick is decoded from the counter so an async reset silences it at once.
  assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign wd_expired  = (wdog == WD_W'(TIMEOUT - 1));
  assign ch_end      = (state == WAIT) && (done_i || wd_expired);
  assign abort       = (state == WAIT) && !done_i && wd_expired;
  assign last_ch     = (ch == CH_W'(NUM_CH - 1));
  assign overrun_set = tick && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (tick || !enable_i) div_cnt <= '0;
    else                        div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (ch_end) state_nxt = last_ch ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch           <= '0;
      wdog         <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (ch_end) ch <= last_ch ? '0 : ch + CH_W'(1);
      if (state == ISSUE)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + WD_W'(1);
      frame_done_q <= ch_end && last_ch;
      // Set has priority over a coincident clear.
      overrun_q    <= overrun_set | (overrun_q & ~clr_i);
      timeout_q    <= abort | (timeout_q & ~clr_i);
    end
  end

`ifdef OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovr_cnt <= 8'd0;
    else if (overrun_set) ovr_cnt <= clr_i ? 8'd1 : ((ovr_cnt == 8'hFF) ? ovr_cnt : ovr_cnt + 8'd1);
    else if (clr_i)       ovr_cnt <= 8'd0;
  end

  assign overrun_cnt_o = ovr_cnt;
`endif

  assign sample_tick_o = tick;
  assign start_o       = (state == ISSUE);
  assign busy_o        = (state != IDLE);
  assign ch_o          = ch;
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_effect_scheduler.sv
// Directed bench for effect_scheduler with CLK_DIV=8, NUM_CH=2, TIMEOUT=4.
// Cycle c means the state seen after c rising edges since enable/reset release; tick T is c=7.
module tb_effect_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, enable_i, clr_i, done_i;
  logic       sample_tick_o, start_o, busy_o, frame_done_o, overrun_o, timeout_o;
  logic [0:0] ch_o;
`ifdef OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  effect_scheduler #(.CLK_DIV(8), .DIV_W(3), .NUM_CH(2), .CH_W(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .clr_i(clr_i), .done_i(done_i),
    .sample_tick_o(sample_tick_o), .start_o(start_o), .ch_o(ch_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
`ifdef OVERRUN_CNT_EN
    , .overrun_cnt_o(overrun_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"}, sample_tick_o, 0);
    chk({tag, "_start"}, start_o, 0);
    chk({tag, "_ch"}, ch_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_fd"}, frame_done_o, 0);
    chk({tag, "_ovr"}, overrun_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
  endtask

  // Reset, enable at cycle 0, and advance to the first tick (c=7).
  task automatic fresh(input logic done_val);
    step();
    rst_n = 1'b0; enable_i = 1'b0; clr_i = 1'b0; done_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b1; enable_i = 1'b1; done_i = done_val;
    repeat (7) step();
    chk("fresh_tick", sample_tick_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1);
  end

  initial begin
    logic e_tick, e_start, e_busy, e_ch, e_fd;
    int r;
    rst_n = 1'b0; enable_i = 1'b0; clr_i = 1'b0; done_i = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
`ifdef OVERRUN_CNT_EN
    chk("reset_cnt", overrun_cnt_o, 0);
`endif

    // 1: ticks at 7,15,23 with datapath always done; frame = ISSUE,WAIT,ISSUE,WAIT.
    rst_n = 1'b1; enable_i = 1'b1; done_i = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      r = c % 8;
      e_tick  = (r == 7);
      e_start = (c >= 8) && (r == 0 || r == 2);
      e_busy  = (c >= 8) && (r <= 3);
      e_ch    = (c >= 8) && (r == 2 || r == 3);
      e_fd    = (c >= 12) && (r == 4);
      chk("t1_tick", sample_tick_o, e_tick);
      chk("t1_start", start_o, e_start);
      chk("t1_busy", busy_o, e_busy);
      chk("t1_ch", ch_o, e_ch);
      chk("t1_fd", frame_done_o, e_fd);
    end
    chk("t1_ovr", overrun_o, 0);
    chk("t1_tmo", timeout_o, 0);

    // 2: done at T+3 and T+6.
    fresh(1'b0);
    step();                       // T+1
    chk("t2_start0", start_o, 1);
    chk("t2_ch0", ch_o, 0);
    chk("t2_busy1", busy_o, 1);
    step();                       // T+2
    chk("t2_nostart", start_o, 0);
    step(); done_i = 1'b1;        // T+3
    step(); done_i = 1'b0;        // T+4
    chk("t2_start1", start_o, 1);
    chk("t2_ch1", ch_o, 1);
    step();                       // T+5
    step(); done_i = 1'b1;        // T+6
    chk("t2_busy6", busy_o, 1);
    chk("t2_fd6", frame_done_o, 0);
    step(); done_i = 1'b0;        // T+7
    chk("t2_fd7", frame_done_o, 1);
    chk("t2_busy7", busy_o, 0);
    chk("t2_ch7", ch_o, 0);
    chk("t2_tmo", timeout_o, 0);
    step();                       // T+8
    chk("t2_fd8", frame_done_o, 0);
    chk("t2_tick8", sample_tick_o, 1);

    // 3: watchdog abort, clear, set-wins-over-clear.
    fresh(1'b0);
    repeat (5) step();            // T+5, last WAIT cycle of ch 0
    chk("t3_tmo5", timeout_o, 0);
    chk("t3_busy5", busy_o, 1);
    chk("t3_ch5", ch_o, 0);
    step();                       // T+6
    chk("t3_tmo6", timeout_o, 1);
    chk("t3_start6", start_o, 1);
    chk("t3_ch6", ch_o, 1);
    clr_i = 1'b1;
    step(); clr_i = 1'b0;         // T+7
    chk("t3_clr", timeout_o, 0);
    step();                       // T+8, tick while busy
    step();                       // T+9
    chk("t3_ovr9", overrun_o, 1);
    step(); clr_i = 1'b1;         // T+10, ch 1 abort cycle
    step(); clr_i = 1'b0;         // T+11
    chk("t3_setwins", timeout_o, 1);
    chk("t3_ovrclr", overrun_o, 0);
    chk("t3_fd11", frame_done_o, 1);
    clr_i = 1'b1;
    step(); clr_i = 1'b0;         // T+12
    chk("t3_clr2", timeout_o, 0);

    // 3b: done in the abort cycle counts as done.
    fresh(1'b0);
    repeat (5) step();            // T+5
    done_i = 1'b1;
    step();                       // T+6
    chk("t3b_start", start_o, 1);
    chk("t3b_ch", ch_o, 1);
    chk("t3b_tmo6", timeout_o, 0);
    step(); step();               // T+8
    chk("t3b_fd", frame_done_o, 1);
    chk("t3b_tmo8", timeout_o, 0);
    chk("t3b_ovr", overrun_o, 0);
    done_i = 1'b0;

    // 4: overruns from frames longer than a sample period (c=7 at entry).
    fresh(1'b0);
    repeat (8) step();            // c=15
    chk("t4_tick15", sample_tick_o, 1);
    chk("t4_busy15", busy_o, 1);
    chk("t4_ovr15", overrun_o, 0);
    step();                       // c=16
    chk("t4_ovr16", overrun_o, 1);
    chk("t4_nostart16", start_o, 0);
    for (int c = 17; c <= 48; c++) begin
      step();
      chk("t4_start", start_o, (c == 24 || c == 29 || c == 40 || c == 45));
    end
    chk("t4_ovr48", overrun_o, 1);
`ifdef OVERRUN_CNT_EN
    chk("t4_cnt", overrun_cnt_o, 3);
`endif

    // 5: enable drops in WAIT of ch 0.
    fresh(1'b0);
    step(); step();               // T+2
    enable_i = 1'b0;
    step(); done_i = 1'b1;        // T+3
    step();                       // T+4
    chk("t5_start", start_o, 1);
    chk("t5_ch", ch_o, 1);
    step(); step();               // T+6
    chk("t5_fd", frame_done_o, 1);
    chk("t5_busy", busy_o, 0);
    done_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t5_notick", sample_tick_o, 0);
    end
    chk("t5_div", dut.div_cnt, 0);

    // 6: async reset mid-WAIT, then restart timing.
    fresh(1'b0);
    step(); step();               // T+2
    chk("t6_busy_pre", busy_o, 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    step();
    chk("t6_hold", busy_o, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("t6_tick", sample_tick_o, (c == 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
